// File: rtl/sobel_frame_ctrl_if.sv
// Purpose : host, source-FIFO and filter-side signals of the sobel frame sequencer.
// Latency : n/a (signal bundle only).
// Backpr. : n/a; src_empty / flt_full carry the stall information.
//
// Ports / signals
//   host  : start, num_frames -> ctrl ; busy, done, frames_done, overrun, timeout <- ctrl
//   src   : src_rd_en <- ctrl ; src_dout, src_empty -> ctrl   (FWFT FIFO read side)
//   flt   : flt_wr_en, flt_din, flt_reset <- ctrl ; flt_full, obs_wr_en -> ctrl
// Modports: master = the frame controller, slave = the surrounding environment.
// DWIDTH and FRAME_CNT_W must match the values given to sobel_frame_ctrl.
interface sobel_frame_ctrl_if #(
   parameter int DWIDTH      = 8,
   parameter int FRAME_CNT_W = 8
);
   // host side
   logic                   start;
   logic [FRAME_CNT_W-1:0] num_frames;
   logic                   busy;
   logic                   done;
   logic [FRAME_CNT_W-1:0] frames_done;
   logic                   overrun;
   logic                   timeout;
   // upstream source FIFO
   logic                   src_rd_en;
   logic [DWIDTH-1:0]      src_dout;
   logic                   src_empty;
   // filter input FIFO, filter reset and observed output strobe
   logic                   flt_wr_en;
   logic [DWIDTH-1:0]      flt_din;
   logic                   flt_full;
   logic                   flt_reset;
   logic                   obs_wr_en;

   modport master (
      input  start, num_frames, src_dout, src_empty, flt_full, obs_wr_en,
      output busy, done, frames_done, overrun, timeout,
             src_rd_en, flt_wr_en, flt_din, flt_reset
   );

   modport slave (
      output start, num_frames, src_dout, src_empty, flt_full, obs_wr_en,
      input  busy, done, frames_done, overrun, timeout,
             src_rd_en, flt_wr_en, flt_din, flt_reset
   );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Purpose : sequences the sobel filter over num_frames frames: reset pulse, feed one frame, wait for drain.
// Latency : source->filter pass-through is combinational (0 cycles); start -> first feed = CLEAR_CYCLES+1.
// Backpr. : a transfer needs !src_empty && !flt_full; either one simply stalls the feed.
//
// Ports
//   clock, reset : single rising-edge clock, synchronous active-high reset
//   bus          : sobel_frame_ctrl_if.master (host control/status, source FIFO, filter FIFO side)
// Optional feature
//   SOBEL_FRAME_CTRL_TIMEOUT_EN : when defined, a drain watchdog of TIMEOUT_CYCLES cycles aborts the
//   run and raises the sticky timeout flag; when undefined timeout is tied low and no counter exists.
module sobel_frame_ctrl #(
   parameter int DWIDTH         = 8,
   parameter int IMG_WIDTH      = 720,
   parameter int IMG_HEIGHT     = 540,
   parameter int FRAME_CNT_W    = 8,
   parameter int CLEAR_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic               clock,
   input  logic               reset,
   sobel_frame_ctrl_if.master bus
);

   localparam int PIX   = IMG_WIDTH * IMG_HEIGHT;
   localparam int CNT_W = $clog2(PIX + 1);
   localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

   localparam logic [CNT_W-1:0]       PIX_C    = CNT_W'(PIX);
   localparam logic [CNT_W-1:0]       PIX_M1   = CNT_W'(PIX - 1);
   localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
   localparam logic [CLR_W-1:0]       CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
   localparam logic [CLR_W-1:0]       CLR_ONE  = CLR_W'(1);
   localparam logic [FRAME_CNT_W-1:0] FRM_ONE  = FRAME_CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CLR_W-1:0]       clr_cnt_q;
   logic [CNT_W-1:0]       in_cnt_q;
   logic [CNT_W-1:0]       out_cnt_q;
   logic [FRAME_CNT_W-1:0] frames_done_q;
   logic [FRAME_CNT_W-1:0] num_lat_q;
   logic [FRAME_CNT_W-1:0] frames_inc;
   logic                   overrun_q;

   logic start_ok;      // start that is actually accepted when idle
   logic xfer;          // one pixel moves source -> filter this cycle
   logic in_last;       // this transfer completes the frame's input side
   logic out_full;      // all PIX outputs of the frame have been observed
   logic last_frame;    // the frame now finishing is the final one of the run
   logic obs_counted;   // obs_wr_en falls inside the expected output window
   logic wd_expire;     // drain watchdog fires this cycle

   assign start_ok    = bus.start && (bus.num_frames != '0);
   assign xfer        = (state_q == ST_FEED) && !bus.src_empty && !bus.flt_full && (in_cnt_q < PIX_C);
   assign in_last     = xfer && (in_cnt_q == PIX_M1);
   assign out_full    = (out_cnt_q == PIX_C);
   assign frames_inc  = frames_done_q + FRM_ONE;
   assign last_frame  = (frames_inc == num_lat_q);
   assign obs_counted = ((state_q == ST_FEED) || (state_q == ST_DRAIN)) && !out_full;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (clr_cnt_q == CLR_LAST) state_d = ST_FEED;
         end
         ST_FEED: begin
            if (in_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // A completed frame wins over a watchdog expiring in the same cycle.
            if (out_full) begin
               state_d = last_frame ? ST_DONE : ST_CLEAR;
            end else if (wd_expire) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (pure decode of the current state plus the FEED pass-through)
   // ------------------------------------------------------------------
   always_comb begin
      bus.busy      = (state_q != ST_IDLE);
      bus.done      = 1'b0;
      bus.flt_reset = 1'b0;
      bus.src_rd_en = 1'b0;
      bus.flt_wr_en = 1'b0;
      bus.flt_din   = '0;
      case (state_q)
         ST_CLEAR: begin
            bus.flt_reset = 1'b1;
         end
         ST_FEED: begin
            bus.src_rd_en = xfer;
            bus.flt_wr_en = xfer;
            bus.flt_din   = bus.src_dout;
         end
         ST_DONE: begin
            bus.done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Counters and host status
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         clr_cnt_q     <= '0;
         in_cnt_q      <= '0;
         out_cnt_q     <= '0;
         frames_done_q <= '0;
         num_lat_q     <= '0;
         overrun_q     <= 1'b0;
      end else begin
         // Reset-pulse length counter only runs while in CLEAR.
         if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + CLR_ONE;
         end else begin
            clr_cnt_q <= '0;
         end

         // Both pixel counters restart in CLEAR, so each frame starts from zero.
         if (state_q == ST_CLEAR) begin
            in_cnt_q <= '0;
         end else if (xfer) begin
            in_cnt_q <= in_cnt_q + CNT_ONE;
         end

         if (state_q == ST_CLEAR) begin
            out_cnt_q <= '0;
         end else if (bus.obs_wr_en && obs_counted) begin
            out_cnt_q <= out_cnt_q + CNT_ONE;
         end

         if ((state_q == ST_IDLE) && start_ok) begin
            num_lat_q     <= bus.num_frames;
            frames_done_q <= '0;
         end else if ((state_q == ST_DRAIN) && out_full) begin
            frames_done_q <= frames_inc;
         end

         // Sticky until the next accepted start; a stray write on the
         // accepting cycle itself still counts as an overrun.
         if (bus.obs_wr_en && !obs_counted) begin
            overrun_q <= 1'b1;
         end else if ((state_q == ST_IDLE) && start_ok) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign bus.frames_done = frames_done_q;
   assign bus.overrun     = overrun_q;

   // ------------------------------------------------------------------
   // Drain watchdog
   // ------------------------------------------------------------------
`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
   localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0]   WD_ONE  = WD_W'(1);

   logic [WD_W-1:0] wd_cnt_q;
   logic            timeout_q;

   // Held at zero outside DRAIN, so DRAIN always starts counting from zero;
   // every observed output write restarts the count.
   always_ff @(posedge clock) begin
      if (reset) begin
         wd_cnt_q <= '0;
      end else if ((state_q == ST_DRAIN) && !bus.obs_wr_en) begin
         wd_cnt_q <= wd_cnt_q + WD_ONE;
      end else begin
         wd_cnt_q <= '0;
      end
   end

   // The cycle seeing TIMEOUT_CYCLES-1 is the one that makes the count reach the limit.
   assign wd_expire = (state_q == ST_DRAIN) && !bus.obs_wr_en && !out_full && (wd_cnt_q == WD_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         timeout_q <= 1'b0;
      end else if ((state_q == ST_IDLE) && start_ok) begin
         timeout_q <= 1'b0;
      end else if (wd_expire) begin
         timeout_q <= 1'b1;
      end
   end

   assign bus.timeout = timeout_q;
`else
   logic [31:0] unused_timeout_cfg;

   assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
   assign wd_expire          = 1'b0;
   assign bus.timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Purpose : self-checking bench for sobel_frame_ctrl with a 4x3 image and a 2-cycle filter reset.
// Latency : one tick() per clock; DUT outputs sampled on the falling edge, inputs driven 1 time unit after rising edge.
// Backpr. : source emptiness and filter fullness are driven randomly / periodically by the bench.
module tb_sobel_frame_ctrl;
   localparam int DW  = 8;
   localparam int FW  = 8;
   localparam int PIX = 12;
   localparam int CLR = 2;
   localparam int TO  = 20;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   sobel_frame_ctrl_if #(.DWIDTH(DW), .FRAME_CNT_W(FW)) bus ();

   sobel_frame_ctrl #(
      .DWIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(3), .FRAME_CNT_W(FW),
      .CLEAR_CYCLES(CLR), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int nf;
      bit full_tog;
      bit empty_rnd;
      bit extra;
      bit busy_start;
      int exp_fd;
      int exp_wr;
      bit exp_ovr;
   } vec_t;

   vec_t vecs[6];

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] src_val [1024];
   int src_idx = 0;
   int exp_idx = 0;
   int cyc     = 0;

   bit full_tog  = 1'b0;
   bit empty_rnd = 1'b0;
   bit extra_obs = 1'b0;
   bit inj_obs   = 1'b0;
   bit start_req = 1'b0;
   logic [FW-1:0] nf_req = '0;
   int obs_limit = 1000;

   // filter model state
   int f_wr    = 0;
   int f_emit  = 0;
   int pending = 0;

   // per-run observations
   int wr_cnt, rd_cnt, data_err, proto_err, done_cnt;
   int rst_pulses, rst_len, rst_len_bad, last_obs, last_wr, to_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      wr_cnt = 0; rd_cnt = 0; data_err = 0; proto_err = 0; done_cnt = 0;
      rst_pulses = 0; rst_len = 0; rst_len_bad = 0;
      last_obs = -1; last_wr = -1; to_cyc = -1;
   endtask

   // One clock: observe the finishing cycle at negedge, update the source and
   // filter models, then drive the next cycle's inputs after the rising edge.
   task automatic tick();
      bit nxt_obs, nxt_empty, nxt_full;
      @(negedge clock);
      cyc++;
      if (bus.src_rd_en === 1'b1) begin
         rd_cnt++;
         src_idx++;
         if (bus.src_empty || bus.flt_full) proto_err++;
      end
      if (bus.flt_wr_en === 1'b1) begin
         wr_cnt++;
         last_wr = cyc;
         if (bus.flt_din !== src_val[exp_idx % 1024]) data_err++;
         exp_idx++;
         f_wr++;
         pending++;
         if (extra_obs && f_wr == PIX) pending++;
      end
      if (bus.obs_wr_en === 1'b1) last_obs = cyc;
      if (bus.done === 1'b1) done_cnt++;
      if (bus.timeout === 1'b1 && to_cyc < 0) to_cyc = cyc;
      if (bus.flt_reset === 1'b1) begin
         rst_len++;
         f_wr = 0; f_emit = 0; pending = 0;
      end else if (rst_len != 0) begin
         rst_pulses++;
         if (rst_len != CLR) rst_len_bad++;
         rst_len = 0;
      end
      nxt_obs = 1'b0;
      if (inj_obs) begin
         nxt_obs = 1'b1;
         inj_obs = 1'b0;
      end else if (pending > 0 && f_emit < obs_limit) begin
         nxt_obs = 1'b1;
         pending--;
         f_emit++;
      end
      nxt_empty = empty_rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      nxt_full  = full_tog && (cyc % 3 == 0);
      @(posedge clock);
      #1;
      bus.src_dout   = src_val[src_idx % 1024];
      bus.src_empty  = nxt_empty;
      bus.flt_full   = nxt_full;
      bus.obs_wr_en  = nxt_obs;
      bus.start      = start_req;
      bus.num_frames = nf_req;
      start_req      = 1'b0;
      #1;
   endtask

   task automatic wait_done(input bit busy_start);
      for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
         if (busy_start && i == 20) begin
            start_req = 1'b1;
            nf_req    = 8'd7;
         end
         tick();
      end
      repeat (6) tick();
   endtask

   task automatic run(input int nf, input bit busy_start);
      clear_stats();
      start_req = 1'b1;
      nf_req    = FW'(nf);
      wait_done(busy_start);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},        bus.busy, 0);
      check({tag, "_done"},        bus.done, 0);
      check({tag, "_frames_done"}, bus.frames_done, 0);
      check({tag, "_overrun"},     bus.overrun, 0);
      check({tag, "_timeout"},     bus.timeout, 0);
      check({tag, "_src_rd_en"},   bus.src_rd_en, 0);
      check({tag, "_flt_wr_en"},   bus.flt_wr_en, 0);
      check({tag, "_flt_reset"},   bus.flt_reset, 0);
      check({tag, "_flt_din"},     bus.flt_din, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL global_watchdog: simulation still running, required finish");
      $fatal(1, "bench stopped by watchdog");
   end

   initial begin
      int ref_cyc;
      for (int i = 0; i < 1024; i++) src_val[i] = DW'($urandom_range(1, 255));

      //           nf  full empty extra bstart fd  wr  ovr
      vecs[0] = '{ 1,  0,   0,    0,    0,     1,  12, 0 };
      vecs[1] = '{ 3,  1,   1,    0,    0,     3,  36, 0 };
      vecs[2] = '{ 2,  0,   1,    0,    1,     2,  24, 0 };
      vecs[3] = '{ 1,  0,   0,    1,    0,     1,  12, 1 };
      vecs[4] = '{ 2,  1,   0,    1,    0,     2,  24, 1 };
      vecs[5] = '{ 4,  1,   0,    0,    0,     4,  48, 0 };

      bus.start      = 1'b0;
      bus.num_frames = '0;
      bus.src_dout   = src_val[0];
      bus.src_empty  = 1'b0;
      bus.flt_full   = 1'b0;
      bus.obs_wr_en  = 1'b0;

      // Reset, then ten idle cycles with a non-empty source.
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      clear_stats();
      repeat (10) tick();
      check_idle_outputs("idle");
      check("idle_reads", rd_cnt, 0);

      // Start timing: reset pulse in the two cycles after acceptance, then feed.
      clear_stats();
      start_req = 1'b1;
      nf_req    = 8'd1;
      tick();
      check("t0_busy", bus.busy, 0);
      tick();
      check("t1_busy", bus.busy, 1);
      check("t1_flt_reset", bus.flt_reset, 1);
      tick();
      check("t2_flt_reset", bus.flt_reset, 1);
      check("t2_src_rd_en", bus.src_rd_en, 0);
      tick();
      check("t3_flt_reset", bus.flt_reset, 0);
      check("t3_src_rd_en", bus.src_rd_en, 1);
      check("t3_flt_wr_en", bus.flt_wr_en, 1);
      check("t3_flt_din", bus.flt_din, src_val[src_idx % 1024]);
      wait_done(1'b0);
      check("t_frames_done", bus.frames_done, 1);
      check("t_writes", wr_cnt, PIX);
      check("t_done_pulses", done_cnt, 1);
      check("t_data_err", data_err, 0);

      // Zero-frame start is ignored.
      clear_stats();
      start_req = 1'b1;
      nf_req    = 8'd0;
      repeat (4) tick();
      check("nf0_busy", bus.busy, 0);
      check("nf0_flt_reset", rst_len + rst_pulses, 0);

      // Table of full runs.
      for (int v = 0; v < 6; v++) begin
         full_tog  = vecs[v].full_tog;
         empty_rnd = vecs[v].empty_rnd;
         extra_obs = vecs[v].extra;
         run(vecs[v].nf, vecs[v].busy_start);
         check($sformatf("v%0d_done_pulses", v), done_cnt, 1);
         check($sformatf("v%0d_frames_done", v), bus.frames_done, vecs[v].exp_fd);
         check($sformatf("v%0d_writes", v), wr_cnt, vecs[v].exp_wr);
         check($sformatf("v%0d_reads", v), rd_cnt, vecs[v].exp_wr);
         check($sformatf("v%0d_data_err", v), data_err, 0);
         check($sformatf("v%0d_proto_err", v), proto_err, 0);
         check($sformatf("v%0d_reset_pulses", v), rst_pulses, vecs[v].nf);
         check($sformatf("v%0d_reset_len_bad", v), rst_len_bad, 0);
         check($sformatf("v%0d_overrun", v), bus.overrun, vecs[v].exp_ovr);
         check($sformatf("v%0d_busy_after", v), bus.busy, 0);
         check($sformatf("v%0d_timeout", v), bus.timeout, 0);
      end
      full_tog  = 1'b0;
      empty_rnd = 1'b0;
      extra_obs = 1'b0;

      // Output write while idle sets overrun; it stays until the next accepted start.
      inj_obs = 1'b1;
      repeat (2) tick();
      check("idle_obs_overrun", bus.overrun, 1);
      repeat (5) tick();
      check("idle_obs_overrun_sticky", bus.overrun, 1);
      clear_stats();
      start_req = 1'b1;
      nf_req    = 8'd1;
      tick();
      tick();
      check("overrun_cleared_on_start", bus.overrun, 0);
      wait_done(1'b0);
      check("post_ovr_frames_done", bus.frames_done, 1);
      check("post_ovr_overrun", bus.overrun, 0);

      // Reset in the middle of FEED abandons the run.
      clear_stats();
      start_req = 1'b1;
      nf_req    = 8'd2;
      for (int i = 0; i < 50 && rd_cnt < 3; i++) tick();
      check("midreset_feed_reached", (rd_cnt >= 3), 1);
      reset   = 1'b1;
      pending = 0;
      tick();
      check_idle_outputs("midreset");
      reset   = 1'b0;
      pending = 0;
      clear_stats();
      repeat (30) tick();
      check("midreset_no_done", done_cnt, 0);
      check("midreset_busy", bus.busy, 0);
      pending = 0;

`ifdef SOBEL_FRAME_CTRL_TIMEOUT_EN
      // Filter stops after 8 outputs; the watchdog counts from the later of the
      // last output write and DRAIN entry (the edge of the final input write),
      // and the flag is set TO edges after that edge, i.e. visible TO+1 samples later.
      obs_limit = 8;
      run(2, 1'b0);
      ref_cyc = (last_obs > last_wr) ? last_obs : last_wr;
      check("to_flag", bus.timeout, 1);
      check("to_frames_done", bus.frames_done, 0);
      check("to_done_pulses", done_cnt, 1);
      check("to_writes", wr_cnt, PIX);
      check("to_latency", to_cyc - ref_cyc, TO + 1);
      obs_limit = 1000;
`else
      ref_cyc = 0;
      check("no_macro_timeout", bus.timeout + ref_cyc, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
